// File: rtl/ifid_hazard_ctrl_pkg.sv
// Shared decode constants, reset defaults and the FSM state type for the IF/ID hazard controller.
// Also holds the small decode predicates used to classify the instruction sitting in ID.
package ifid_hazard_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'h00;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;

    // sll $0,$0,0
    localparam logic [31:0] DEFAULT_NOP_INS = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

    function automatic logic is_mfhilo(input logic [5:0] op, input logic [5:0] funct);
        return (op == OP_RTYPE) && ((funct == FN_MFHI) || (funct == FN_MFLO));
    endfunction

    function automatic logic is_muldiv(input logic [5:0] op, input logic [5:0] funct);
        return (op == OP_RTYPE) &&
               ((funct == FN_MULT) || (funct == FN_MULTU) ||
                (funct == FN_DIV)  || (funct == FN_DIVU));
    endfunction

    function automatic logic is_sys(input logic [5:0] op, input logic [5:0] funct);
        return (op == OP_RTYPE) && (funct == FN_SYSCALL);
    endfunction

endpackage

// File: rtl/ifid_hazard_ctrl_parser.sv
// Field splitter for a MIPS instruction word: opcode, rs, rt and funct.
// Only the fields needed for hazard decode are exported.
module parser (
    input  logic [31:0] ins,
    output logic [5:0]  op,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [5:0]  funct
);

    // rd/shamt/immediate bits are not needed by the hazard logic
    logic unused_fields;

    always_comb begin
        op            = ins[31:26];
        rs            = ins[25:21];
        rt            = ins[20:16];
        funct         = ins[5:0];
        unused_fields = ^ins[15:6];
    end

endmodule

// File: rtl/ifid_hazard_ctrl.sv
// IF/ID pipeline register with ID-stage hazard sequencing: load-use stall, branch flush,
// HI/LO busy interlock for mfhi/mflo, and a syscall HALT state left via resume.
module ifid_hazard_ctrl
    import ifid_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = 4,
    parameter logic [31:0] NOP_INS    = DEFAULT_NOP_INS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_ins,
    input  logic [31:0] if_pc,
    input  logic        if_valid,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        branch_taken,
    input  logic        resume,
    output logic [31:0] id_ins,
    output logic [31:0] id_pc,
    output logic        id_valid,
    output logic        pc_stall,
    output logic        idex_bubble,
    output logic        muldiv_busy,
    output logic        halted
);

    localparam logic [3:0] LAT_CNT = 4'(MULDIV_LAT);

    state_t      state;
    state_t      state_next;

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [5:0]  funct;

    logic [3:0]  busy_cnt;
    logic        load_use;
    logic        hilo_wait;
    logic        stall;
    logic        advance;
    logic        flush;
    logic        sys_leaving;

    parser u_parser (
        .ins   (id_ins),
        .op    (op),
        .rs    (rs),
        .rt    (rt),
        .funct (funct)
    );

    always_comb begin
        load_use    = id_valid && ex_memread && (ex_rt != 5'd0) &&
                      ((rs == ex_rt) || (reads_rt(op) && (rt == ex_rt)));
        hilo_wait   = id_valid && is_mfhilo(op, funct) && muldiv_busy;
        stall       = (state == RUN) && (load_use || hilo_wait);
        sys_leaving = id_valid && is_sys(op, funct);
        muldiv_busy = (busy_cnt != 4'd0);
        halted      = (state == HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:  if (advance && sys_leaving) state_next = HALT;
            HALT: if (resume) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // A taken branch wins over a coincident stall, so the flush path drops the stall outputs.
    always_comb begin
        pc_stall    = 1'b0;
        idex_bubble = 1'b0;
        advance     = 1'b0;
        flush       = 1'b0;
        case (state)
            RUN: begin
                if (branch_taken) begin
                    flush = 1'b1;
                end else if (stall) begin
                    pc_stall    = 1'b1;
                    idex_bubble = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end
            HALT: begin
                pc_stall    = 1'b1;
                idex_bubble = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ins   <= NOP_INS;
            id_pc    <= '0;
            id_valid <= 1'b0;
            busy_cnt <= '0;
        end else begin
            if (flush || (advance && sys_leaving)) begin
                id_ins   <= NOP_INS;
                id_pc    <= '0;
                id_valid <= 1'b0;
            end else if (advance) begin
                id_ins   <= if_ins;
                id_pc    <= if_pc;
                id_valid <= if_valid;
            end

            // Counter free-runs through stall, flush and HALT; only a retiring mult/div reloads it.
            if (advance && id_valid && is_muldiv(op, funct)) begin
                busy_cnt <= LAT_CNT;
            end else if (busy_cnt != 4'd0) begin
                busy_cnt <= busy_cnt - 4'd1;
            end
        end
    end

endmodule
